dds_sweep_ctrl: RTL and testbench

Frequency-sweep scheduler for the DDS phase-accumulator/sine-ROM path. It generates the 32-bit frequency control word and 8-bit phase control word consumed by the accumulator. It steps the frequency from a start value to a stop value in fixed increments and holds each word for a programmable dwell time. It sits between the register/configuration logic and the DDS address generator, replacing the constant frequency and phase words with run-time-sequenced values.

---
 rtl/dds_ctrl_pkg.sv | 31 +++
 rtl/dds_dwell_timer.sv | 29 ++
 rtl/dds_sweep_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_ctrl_pkg.sv
// Shared types and default widths for the DDS sweep controller.
// Optional triangle (up/down) sweep is enabled with DDS_SWEEP_TRIANGLE_EN.
package dds_ctrl_pkg;

  localparam int unsigned DdsN  = 32;
  localparam int unsigned DdsPw = 8;
  localparam int unsigned DdsDw = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StUp   = 2'd1
`ifdef DDS_SWEEP_TRIANGLE_EN
    ,
    StDown = 2'd2
`endif
  } sweep_state_e;

  typedef struct packed {
    logic [DdsN-1:0]  f_start;
    logic [DdsN-1:0]  f_stop;
    logic [DdsN-1:0]  f_step;
    logic [DdsDw-1:0] dwell;
    logic [DdsPw-1:0] pword;
  } sweep_cfg_t;

  // A programmed dwell of zero behaves as one cycle per word.
  function automatic logic [DdsDw-1:0] eff_dwell(input logic [DdsDw-1:0] d);
    return (d == '0) ? {{(DdsDw-1){1'b0}}, 1'b1} : d;
  endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable dwell down-counter; expire flags the last cycle of a dwell period.
module dds_dwell_timer #(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_value,
  output logic [DW-1:0] value,
  output logic          expire
);

  logic [DW-1:0] value_q;

  // Count down towards zero, reload on request; rests at zero when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= load_value;
    end else if (value_q != '0) begin
      value_q <= value_q - 1'b1;
    end
  end

  assign value  = value_q;
  assign expire = (value_q == {{(DW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler for the DDS accumulator: steps fword from start to stop,
// holding each word for a programmable dwell. Define DDS_SWEEP_TRIANGLE_EN for a
// continuous up/down sweep instead of a single upward pass.
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int unsigned N  = DdsN,
  parameter int unsigned PW = DdsPw,
  parameter int unsigned DW = DdsDw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [N-1:0]  cfg_f_start,
  input  logic [N-1:0]  cfg_f_stop,
  input  logic [N-1:0]  cfg_f_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [PW-1:0] cfg_pword,
  input  logic          start,
  input  logic          abort,
  output logic [N-1:0]  fword,
  output logic [PW-1:0] pword,
  output logic          upd,
  output logic          busy,
  output logic          done
);

  sweep_state_e state_q, state_d;
  sweep_cfg_t   cfg_q, cfg_in, cfg_eff;

  logic [N-1:0]  fword_q, fword_d;
  logic [PW-1:0] pword_q, pword_d;
  logic          upd_q, upd_d, busy_q, done_q, done_d, cfg_ready_q;

  logic          cfg_take;
  logic [N-1:0]  stop_eff, add_sat;
  logic [N:0]    add_sum;
  logic          tmr_load, tmr_expire;
  logic [DW-1:0] tmr_load_value, tmr_value;
  logic          unused_tmr_value;

  assign cfg_take = cfg_valid && cfg_ready_q;
  assign cfg_in   = '{f_start: cfg_f_start, f_stop: cfg_f_stop, f_step: cfg_f_step,
                      dwell: cfg_dwell, pword: cfg_pword};
  // A config offered in the start cycle takes effect immediately.
  assign cfg_eff  = cfg_take ? cfg_in : cfg_q;

  // An inverted range collapses to a single-word sweep.
  assign stop_eff = (cfg_q.f_stop < cfg_q.f_start) ? cfg_q.f_start : cfg_q.f_stop;
  // One extra bit so the step can never wrap past the stop word.
  assign add_sum  = {1'b0, fword_q} + {1'b0, cfg_q.f_step};
  assign add_sat  = (add_sum > {1'b0, stop_eff}) ? stop_eff : add_sum[N-1:0];

`ifdef DDS_SWEEP_TRIANGLE_EN
  logic [N-1:0] sub_sat;
  // fword never drops below f_start, so the distance check avoids underflow.
  assign sub_sat = ((fword_q - cfg_q.f_start) > cfg_q.f_step) ? (fword_q - cfg_q.f_step)
                                                              : cfg_q.f_start;
`endif

  dds_dwell_timer #(
    .DW(DW)
  ) u_dwell_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (tmr_load),
    .load_value(tmr_load_value),
    .value     (tmr_value),
    .expire    (tmr_expire)
  );

  assign unused_tmr_value = ^tmr_value;

  // Shadow configuration, written only on an accepted handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q <= '0;
    end else if (cfg_take) begin
      cfg_q <= cfg_in;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides everything.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (start) state_d = StUp;
        StUp: begin
          if (tmr_expire && (fword_q == stop_eff)) begin
`ifdef DDS_SWEEP_TRIANGLE_EN
            state_d = StDown;
`else
            state_d = StIdle;
`endif
          end
        end
`ifdef DDS_SWEEP_TRIANGLE_EN
        StDown: if (tmr_expire && (fword_q == cfg_q.f_start)) state_d = StUp;
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  // Output next values: new word, update strobe, dwell reload and completion pulse.
  always_comb begin
    fword_d        = fword_q;
    pword_d        = pword_q;
    upd_d          = 1'b0;
    done_d         = 1'b0;
    tmr_load       = 1'b0;
    tmr_load_value = eff_dwell(cfg_q.dwell);
    if (!abort) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            fword_d        = cfg_eff.f_start;
            pword_d        = cfg_eff.pword;
            upd_d          = 1'b1;
            tmr_load       = 1'b1;
            tmr_load_value = eff_dwell(cfg_eff.dwell);
          end
        end
        StUp: begin
          if (tmr_expire) begin
            if (fword_q != stop_eff) begin
              fword_d  = add_sat;
              upd_d    = 1'b1;
              tmr_load = 1'b1;
            end else begin
`ifdef DDS_SWEEP_TRIANGLE_EN
              fword_d  = sub_sat;
              upd_d    = 1'b1;
              tmr_load = 1'b1;
`else
              done_d   = 1'b1;
`endif
            end
          end
        end
`ifdef DDS_SWEEP_TRIANGLE_EN
        StDown: begin
          if (tmr_expire) begin
            fword_d  = (fword_q != cfg_q.f_start) ? sub_sat : add_sat;
            upd_d    = 1'b1;
            tmr_load = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fword_q     <= '0;
      pword_q     <= '0;
      upd_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      fword_q     <= fword_d;
      pword_q     <= pword_d;
      upd_q       <= upd_d;
      done_q      <= done_d;
      busy_q      <= (state_d != StIdle);
      cfg_ready_q <= (state_d == StIdle);
    end
  end

  assign fword     = fword_q;
  assign pword     = pword_q;
  assign upd       = upd_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: table of sweeps plus hand-written corner sequences.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready;
  logic [31:0] cfg_f_start, cfg_f_stop, cfg_f_step;
  logic [15:0] cfg_dwell;
  logic [7:0]  cfg_pword;
  logic        start, abort;
  logic [31:0] fword;
  logic [7:0]  pword;
  logic        upd, busy, done;

  int total = 0;
  int bad   = 0;

  dds_sweep_ctrl u_dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_f_start(cfg_f_start),
    .cfg_f_stop (cfg_f_stop),
    .cfg_f_step (cfg_f_step),
    .cfg_dwell  (cfg_dwell),
    .cfg_pword  (cfg_pword),
    .start      (start),
    .abort      (abort),
    .fword      (fword),
    .pword      (pword),
    .upd        (upd),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      f_start;
    logic [31:0]      f_stop;
    logic [31:0]      f_step;
    logic [15:0]      dwell;
    logic [7:0]       pw;
    int               nwords;
    logic [3:0][31:0] w;
    int               done_cyc;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                         input logic [15:0] d, input logic [7:0] p);
    cfg_f_start = s;
    cfg_f_stop  = e;
    cfg_f_step  = st;
    cfg_dwell   = d;
    cfg_pword   = p;
  endtask

  // Configure through the handshake, then start on the following edge.
  task automatic cfg_then_start(input logic [31:0] s, input logic [31:0] e,
                                input logic [31:0] st, input logic [15:0] d,
                                input logic [7:0] p);
    set_cfg(s, e, st, d, p);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    int d;
    int k;
    vecs[0] = '{32'd100, 32'd130, 32'd10, 16'd3, 8'h5A, 4,
                {32'd130, 32'd120, 32'd110, 32'd100}, 13};
    vecs[1] = '{32'd100, 32'd125, 32'd10, 16'd3, 8'hA5, 4,
                {32'd125, 32'd120, 32'd110, 32'd100}, 13};
    vecs[2] = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0, 8'h01, 2,
                {32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0}, 3};
    vecs[3] = '{32'd500, 32'd200, 32'd7, 16'd2, 8'h3C, 1,
                {32'd0, 32'd0, 32'd0, 32'd500}, 3};

    rst = 1'b1;
    cfg_valid = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    set_cfg(32'd0, 32'd0, 32'd0, 16'd0, 8'd0);
    @(negedge clk);
    tick();
    tick();
    chk("rst_fword", fword, 32'd0);
    chk("rst_pword", {24'd0, pword}, 32'd0);
    chk("rst_upd", {31'd0, upd}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);

`ifndef DDS_SWEEP_TRIANGLE_EN
    // Table-driven single sweeps.
    for (int v = 0; v < 4; v++) begin
      d = (vecs[v].dwell == 16'd0) ? 1 : int'(vecs[v].dwell);
      cfg_then_start(vecs[v].f_start, vecs[v].f_stop, vecs[v].f_step, vecs[v].dwell,
                     vecs[v].pw);
      chk($sformatf("v%0d_pword", v), {24'd0, pword}, {24'd0, vecs[v].pw});
      for (int c = 1; c <= vecs[v].done_cyc; c++) begin
        if (c > 1) tick();
        if (c < vecs[v].done_cyc) begin
          k = (c - 1) / d;
          chk($sformatf("v%0d_c%0d_fword", v, c), fword, vecs[v].w[k]);
          chk($sformatf("v%0d_c%0d_upd", v, c), {31'd0, upd},
              {31'd0, ((c - 1) % d) == 0});
          chk($sformatf("v%0d_c%0d_busy", v, c), {31'd0, busy}, 32'd1);
          chk($sformatf("v%0d_c%0d_done", v, c), {31'd0, done}, 32'd0);
          chk($sformatf("v%0d_c%0d_cfg_ready", v, c), {31'd0, cfg_ready}, 32'd0);
        end else begin
          chk($sformatf("v%0d_end_fword", v), fword, vecs[v].w[vecs[v].nwords-1]);
          chk($sformatf("v%0d_end_upd", v), {31'd0, upd}, 32'd0);
          chk($sformatf("v%0d_end_busy", v), {31'd0, busy}, 32'd0);
          chk($sformatf("v%0d_end_done", v), {31'd0, done}, 32'd1);
          chk($sformatf("v%0d_end_cfg_ready", v), {31'd0, cfg_ready}, 32'd1);
        end
      end
      tick();
      chk($sformatf("v%0d_done_pulse", v), {31'd0, done}, 32'd0);
    end

    // Abort during the second word of the basic sweep.
    cfg_then_start(32'd100, 32'd130, 32'd10, 16'd3, 8'h11);
    for (int c = 2; c <= 5; c++) tick();
    chk("abort_pre_fword", fword, 32'd110);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_fword", fword, 32'd110);
    chk("abort_upd", {31'd0, upd}, 32'd0);
    chk("abort_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    chk("abort_hold_fword", fword, 32'd110);

    // Config and start in the same cycle: the new config must be used.
    set_cfg(32'd1000, 32'd1000, 32'd1, 16'd1, 8'h33);
    cfg_valid = 1'b1;
    start     = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start     = 1'b0;
    chk("bypass_fword", fword, 32'd1000);
    chk("bypass_pword", {24'd0, pword}, 32'h33);
    chk("bypass_upd", {31'd0, upd}, 32'd1);
    tick();
    chk("bypass_done", {31'd0, done}, 32'd1);

    // Start and config offers while busy are ignored.
    cfg_then_start(32'd100, 32'd130, 32'd10, 16'd3, 8'h44);
    tick();
    chk("busy_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    set_cfg(32'd7, 32'd9, 32'd1, 16'd1, 8'h99);
    cfg_valid = 1'b1;
    start     = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start     = 1'b0;
    chk("busy_start_fword", fword, 32'd100);
    chk("busy_start_upd", {31'd0, upd}, 32'd0);
    chk("busy_start_pword", {24'd0, pword}, 32'h44);
    for (int c = 4; c <= 13; c++) tick();
    chk("busy_run_done", {31'd0, done}, 32'd1);
    chk("busy_run_fword", fword, 32'd130);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("shadow_kept_fword", fword, 32'd100);
    chk("shadow_kept_pword", {24'd0, pword}, 32'h44);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`else
    // Triangle sweep: 100,110,120,130,120,110,100,110,120 with no completion.
    begin
      logic [31:0] tri_w[9];
      tri_w = '{32'd100, 32'd110, 32'd120, 32'd130, 32'd120, 32'd110, 32'd100, 32'd110,
                32'd120};
      cfg_then_start(32'd100, 32'd130, 32'd10, 16'd3, 8'h5A);
      for (int c = 1; c <= 27; c++) begin
        if (c > 1) tick();
        chk($sformatf("tri_c%0d_fword", c), fword, tri_w[(c-1)/3]);
        chk($sformatf("tri_c%0d_upd", c), {31'd0, upd}, {31'd0, ((c - 1) % 3) == 0});
        chk($sformatf("tri_c%0d_done", c), {31'd0, done}, 32'd0);
        chk($sformatf("tri_c%0d_busy", c), {31'd0, busy}, 32'd1);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("tri_abort_busy", {31'd0, busy}, 32'd0);
      chk("tri_abort_fword", fword, 32'd120);
      chk("tri_abort_done", {31'd0, done}, 32'd0);
      chk("tri_abort_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    end
`endif

    // Reset mid-sweep returns everything to the reset state.
    cfg_then_start(32'd100, 32'd130, 32'd10, 16'd3, 8'h22);
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_fword", fword, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    rst = 1'b0;
    tick();
    chk("midrst_cfg_ready_after", {31'd0, cfg_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
